data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 64: number of 32-bit data words stored.
REQ-002 SHALL have parameter LATENCY, default 2: cycles from request acceptance to resp_valid, legal range 1..15.
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  processor presents a load/store request.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request this cycle.
REQ-007 SHALL have port req_write  input  1  1 = store (sw), 0 = load (lw).
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data.
REQ-010 SHALL have port resp_valid  output  1  response available.
REQ-011 SHALL have port resp_ready  input  1  processor accepts the response.
REQ-012 SHALL have port resp_rdata  output  32  load data; 0 for stores and errors.
REQ-013 SHALL have port resp_err  output  1  request was misaligned or out of range.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-015 SHALL drive req_ready=1 only in IDLE. A request is accepted when req_valid && req_ready.
REQ-016 On acceptance, SHALL latch the word index req_addr[31:2], req_write, and the error flag.
REQ-017 Error flag SHALL be (req_addr[1:0]!=0) || (req_addr[31:2] >= DEPTH_WORDS).
REQ-018 Accepted store without error SHALL write req_wdata to memory at the acceptance clock edge. A store with error SHALL leave memory unchanged.
REQ-019 Accepted load without error SHALL capture the memory word at acceptance. A store in the same cycle is impossible because only one request is accepted per transaction.
REQ-020 Acceptance in cycle N SHALL produce resp_valid=1 in cycle N+LATENCY. For LATENCY=1, IDLE SHALL go directly to RESP. Otherwise BUSY SHALL count LATENCY-1 cycles using a 4-bit down-counter.
REQ-021 In RESP, resp_valid, resp_rdata and resp_err SHALL hold stable until resp_valid && resp_ready.
REQ-022 On that handshake, SHALL return to IDLE next cycle. resp_valid SHALL drop and req_ready SHALL rise in the same cycle.
REQ-023 Outside RESP, SHALL drive resp_valid=0, resp_rdata=0 and resp_err=0.
REQ-024 resp_rdata SHALL be 0 for stores and for any errored request.
REQ-025 req_valid asserted outside IDLE SHALL be ignored and not queued. req_addr/req_wdata changes outside IDLE SHALL have no effect.
REQ-026 resp_ready asserted outside RESP SHALL have no effect.
REQ-027 Back-to-back throughput SHALL be one transaction per LATENCY+1 cycles when resp_ready is held 1.

Reset
REQ-028 rst=1 at a clock edge SHALL force IDLE, zero the counter, and drive req_ready=1 with resp_valid, resp_err and resp_rdata at 0 in the following cycle.
REQ-029 Reset during BUSY or RESP SHALL discard the pending response. A store already accepted before reset SHALL remain written.
REQ-030 Memory contents SHALL NOT be cleared by reset. Contents SHALL be undefined until written.
REQ-031 rst SHALL take priority over a simultaneous req_valid. No request is accepted and no write occurs in a reset cycle.

Verification
REQ-032 Store-then-load, resp_ready held 1: store addr 0x00000010 data 0xDEADBEEF, then load 0x10 -> resp_valid 2 cycles after each acceptance. Load returns resp_rdata=0xDEADBEEF, resp_err=0. Store returns resp_rdata=0.
REQ-033 Misaligned store to 0x00000013 with data 0x12345678, then load 0x10 -> store gets resp_err=1, and the load returns 0xDEADBEEF (unchanged).
REQ-034 Out-of-range load 0x00000100 (word 64, DEPTH_WORDS=64) -> resp_err=1, resp_rdata=0. Load 0x000000FC (word 63) -> resp_err=0.
REQ-035 Backpressure: hold resp_ready=0 for 5 cycles after resp_valid rises -> resp_valid/resp_rdata stay stable and req_ready stays 0. Raise resp_ready -> IDLE next cycle.
REQ-036 Reset mid-BUSY after accepting a load -> no resp_valid ever appears for it, and req_ready=1 the cycle after rst.
REQ-037 LATENCY=1 build: load accepted in cycle N -> resp_valid=1 in cycle N+1. Re-run REQ-032 and REQ-035 with this build.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder: word-addressed data memory answering one load/store per handshake after a fixed latency
module data_mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state;
  logic [3:0] cnt;
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q;
  logic err_q;
  logic addr_err;
  logic [AW-1:0] idx;
  assign addr_err = (req_addr[1:0] != 2'b0) || ({2'b0, req_addr[31:2]} >= 32'(DEPTH_WORDS));
  assign idx = req_addr[AW+1:2];
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= 4'd0;
      req_ready <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err <= 1'b0;
      rdata_q <= 32'd0;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          req_ready <= 1'b0;
          err_q <= addr_err;
          rdata_q <= (req_write || addr_err) ? 32'd0 : mem[idx];
          if (req_write && !addr_err) mem[idx] <= req_wdata;
          if (LATENCY == 1) begin
            state <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= (req_write || addr_err) ? 32'd0 : mem[idx];
            resp_err <= addr_err;
          end else begin
            state <= BUSY;
            cnt <= 4'(LATENCY - 2);
          end
        end
        BUSY: if (cnt == 4'd0) begin
          state <= RESP;
          resp_valid <= 1'b1;
          resp_rdata <= rdata_q;
          resp_err <= err_q;
        end else begin
          cnt <= cnt - 4'd1;
        end
        RESP: if (resp_ready) begin
          state <= IDLE;
          req_ready <= 1'b1;
          resp_valid <= 1'b0;
          resp_rdata <= 32'd0;
          resp_err <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed checks of the data memory responder at latency 2 and latency 1
module tb_data_mem_responder;
  logic clk = 0, rst = 1, req_valid = 0, req_write = 0, resp_ready = 1, sel = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic rdy0, rdy1, rv0, rv1, err0, err1;
  logic [31:0] rd0, rd1;
  logic req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  int total = 0, bad = 0, exp_lat = 2;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(64), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid && !sel), .req_ready(rdy0), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv0), .resp_ready(resp_ready),
    .resp_rdata(rd0), .resp_err(err0)
  );
  data_mem_responder #(.DEPTH_WORDS(64), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid && sel), .req_ready(rdy1), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv1), .resp_ready(resp_ready),
    .resp_rdata(rd1), .resp_err(err1)
  );

  assign req_ready = sel ? rdy1 : rdy0;
  assign resp_valid = sel ? rv1 : rv0;
  assign resp_rdata = sel ? rd1 : rd0;
  assign resp_err = sel ? err1 : err0;

  task automatic transact(input logic w, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rdata, output logic err, output int lat);
    req_valid = 1; req_write = w; req_addr = a; req_wdata = d;
    lat = -1; rdata = 32'hX; err = 1'bX;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      req_valid = 0; req_addr = 32'hFFFF_FFF0; req_wdata = 32'h0BAD_0BAD;
      if (resp_valid) begin lat = i; rdata = resp_rdata; err = resp_err; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (2) @(negedge clk);
    total++; if (rdy0 !== 1'b1 || rdy1 !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b/%b exp=1/1", rdy0, rdy1); end
    total++; if (rv0 !== 1'b0 || rv1 !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b/%b exp=0/0", rv0, rv1); end
    total++; if (rd0 !== 32'd0 || rd1 !== 32'd0) begin bad++; $display("FAIL reset_rdata got=%h/%h exp=0/0", rd0, rd1); end
    total++; if (err0 !== 1'b0 || err1 !== 1'b0) begin bad++; $display("FAIL reset_err got=%b/%b exp=0/0", err0, err1); end
    rst = 0;
  endtask

  task automatic test_store_load;
    logic [31:0] rd; logic er; int lat;
    resp_ready = 1;
    transact(1, 32'h10, 32'hDEADBEEF, rd, er, lat);
    total++; if (lat !== exp_lat) begin bad++; $display("FAIL sl_store_lat got=%0d exp=%0d", lat, exp_lat); end
    total++; if (rd !== 32'd0 || er !== 1'b0) begin bad++; $display("FAIL sl_store_resp got=%h/%b exp=0/0", rd, er); end
    @(negedge clk);
    total++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin bad++; $display("FAIL sl_idle got=%b/%b exp=1/0", req_ready, resp_valid); end
    transact(0, 32'h10, 32'h0, rd, er, lat);
    total++; if (lat !== exp_lat) begin bad++; $display("FAIL sl_load_lat got=%0d exp=%0d", lat, exp_lat); end
    total++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin bad++; $display("FAIL sl_load_resp got=%h/%b exp=deadbeef/0", rd, er); end
    @(negedge clk);
  endtask

  task automatic test_misaligned;
    logic [31:0] rd; logic er; int lat;
    transact(1, 32'h13, 32'h12345678, rd, er, lat);
    total++; if (rd !== 32'd0 || er !== 1'b1) begin bad++; $display("FAIL mis_store got=%h/%b exp=0/1", rd, er); end
    @(negedge clk);
    transact(0, 32'h12, 32'h0, rd, er, lat);
    total++; if (rd !== 32'd0 || er !== 1'b1) begin bad++; $display("FAIL mis_load got=%h/%b exp=0/1", rd, er); end
    @(negedge clk);
    transact(0, 32'h10, 32'h0, rd, er, lat);
    total++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin bad++; $display("FAIL mis_unchanged got=%h/%b exp=deadbeef/0", rd, er); end
    @(negedge clk);
  endtask

  task automatic test_range;
    logic [31:0] rd; logic er; int lat;
    transact(0, 32'h100, 32'h0, rd, er, lat);
    total++; if (rd !== 32'd0 || er !== 1'b1) begin bad++; $display("FAIL rng_load64 got=%h/%b exp=0/1", rd, er); end
    @(negedge clk);
    transact(1, 32'hFC, 32'h600DF00D, rd, er, lat);
    total++; if (er !== 1'b0) begin bad++; $display("FAIL rng_store63 err got=%b exp=0", er); end
    @(negedge clk);
    transact(0, 32'hFC, 32'h0, rd, er, lat);
    total++; if (rd !== 32'h600DF00D || er !== 1'b0) begin bad++; $display("FAIL rng_load63 got=%h/%b exp=600df00d/0", rd, er); end
    @(negedge clk);
    transact(1, 32'h0, 32'hCAFEF00D, rd, er, lat);
    @(negedge clk);
    transact(1, 32'h100, 32'h55555555, rd, er, lat);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL rng_store64 err got=%b exp=1", er); end
    @(negedge clk);
    transact(0, 32'h0, 32'h0, rd, er, lat);
    total++; if (rd !== 32'hCAFEF00D || er !== 1'b0) begin bad++; $display("FAIL rng_word0 got=%h/%b exp=cafef00d/0", rd, er); end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    logic [31:0] rd; logic er; int lat;
    resp_ready = 0;
    transact(0, 32'h10, 32'h0, rd, er, lat);
    total++; if (lat !== exp_lat || rd !== 32'hDEADBEEF) begin bad++; $display("FAIL bp_first got=%0d/%h exp=%0d/deadbeef", lat, rd, exp_lat); end
    for (int i = 0; i < 5; i++) begin
      req_valid = 1; req_write = 1; req_addr = 32'h10; req_wdata = 32'h0;
      @(negedge clk);
      total++;
      if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEADBEEF || resp_err !== 1'b0 || req_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold%0d got=%b/%h/%b/%b exp=1/deadbeef/0/0", i, resp_valid, resp_rdata, resp_err, req_ready);
      end
    end
    req_valid = 0; resp_ready = 1;
    @(negedge clk);
    total++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%b/%b exp=0/1", resp_valid, req_ready); end
    transact(0, 32'h10, 32'h0, rd, er, lat);
    total++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin bad++; $display("FAIL bp_ignored_store got=%h/%b exp=deadbeef/0", rd, er); end
    @(negedge clk);
  endtask

  task automatic abort_req(input logic w, input logic [31:0] a, input logic [31:0] d, input string tag);
    int seen;
    req_valid = 1; req_write = w; req_addr = a; req_wdata = d;
    @(negedge clk);
    rst = 1; req_valid = 1; req_write = 1; req_addr = 32'h10; req_wdata = 32'h0;
    repeat (2) @(negedge clk);
    rst = 0; req_valid = 0;
    total++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin bad++; $display("FAIL %s_after_rst got=%b/%b exp=1/0", tag, req_ready, resp_valid); end
    seen = 0;
    repeat (5) begin @(negedge clk); if (resp_valid) seen++; end
    total++; if (seen !== 0) begin bad++; $display("FAIL %s_no_resp got=%0d exp=0", tag, seen); end
  endtask

  task automatic test_reset_busy;
    logic [31:0] rd; logic er; int lat;
    abort_req(0, 32'h10, 32'h0, "rb_load");
    abort_req(1, 32'h20, 32'h11112222, "rb_store");
    transact(0, 32'h20, 32'h0, rd, er, lat);
    total++; if (rd !== 32'h11112222 || er !== 1'b0) begin bad++; $display("FAIL rb_store_kept got=%h/%b exp=11112222/0", rd, er); end
    @(negedge clk);
    transact(0, 32'h10, 32'h0, rd, er, lat);
    total++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin bad++; $display("FAIL rb_no_write_in_rst got=%h/%b exp=deadbeef/0", rd, er); end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    sel = 0; exp_lat = 2;
    test_store_load;
    test_misaligned;
    test_range;
    test_backpressure;
    test_reset_busy;
    sel = 1; exp_lat = 1;
    @(negedge clk);
    test_store_load;
    test_backpressure;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
